// File: rtl/control_suma_multipalabra.sv
// rtl/control_suma_multipalabra.sv - multi-word adder sequencer around an external WIDTH-bit adder
// Optional feature: define SUMA_OVF_EN to register the signed overflow flag on ovf_o.
module control_suma_multipalabra #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [WIDTH*WORDS-1:0]   a_i,
  input  logic [WIDTH*WORDS-1:0]   b_i,
  input  logic                     cin_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH*WORDS-1:0]   result_o,
  output logic                     cout_o,
  output logic                     ovf_o,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  output logic                     add_cin_o,
  input  logic [WIDTH-1:0]         add_sum_i,
  input  logic                     add_c_i
);

  localparam int W    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state logic and adder drive: one word per RUN cycle, LSW first.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    cout_d    = cout_q;
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a_o   = a_q[idx_q*WIDTH +: WIDTH];
        add_b_o   = b_q[idx_q*WIDTH +: WIDTH];
        add_cin_o = carry_q;
        result_d[idx_q*WIDTH +: WIDTH] = add_sum_i;
        carry_d = add_c_i;
        if (idx_q == LAST_IDX) begin
          // Index wraps to zero so it never leaves 0..WORDS-1.
          idx_d   = '0;
          cout_d  = add_c_i;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;

`ifdef SUMA_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow from the top word: like-signed operands giving an opposite-signed sum.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && idx_q == LAST_IDX) begin
      ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum_i[WIDTH-1] != a_q[W-1]);
    end
  end

  // Overflow flag register, held between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_suma_multipalabra.sv
// tb/tb_control_suma_multipalabra.sv - randomized self-checking bench for control_suma_multipalabra (honours SUMA_OVF_EN)
module tb_control_suma_multipalabra;

  localparam int WIDTH = 8;
  localparam int WORDS = 2;
  localparam int W     = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [W-1:0]     a_i, b_i;
  logic             cin_i;
  logic             busy_o, done_o, cout_o, ovf_o;
  logic [W-1:0]     result_o;
  logic [WIDTH-1:0] add_a_o, add_b_o, add_sum_i;
  logic             add_cin_o, add_c_i;

  int n_checks = 0;
  int n_pass   = 0;

  control_suma_multipalabra #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .cin_i     (cin_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .cout_o    (cout_o),
    .ovf_o     (ovf_o),
    .add_a_o   (add_a_o),
    .add_b_o   (add_b_o),
    .add_cin_o (add_cin_o),
    .add_sum_i (add_sum_i),
    .add_c_i   (add_c_i)
  );

  // Behavioural stand-in for the external Sumador_BK adder.
  assign {add_c_i, add_sum_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {{WIDTH{1'b0}}, add_cin_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected carry into word k: carry out of the sum of the lower k words.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int k);
    logic [63:0] mask, s;
    mask = (64'd1 << (k * WIDTH)) - 64'd1;
    s = ({48'd0, a} & mask) + ({48'd0, b} & mask) + {63'd0, cin};
    return s[k * WIDTH];
  endfunction

  // Full operation: expected result, carry and overflow come from plain wide arithmetic.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit noisy);
    logic [W:0]   full;
    logic [W-1:0] exp_res;
    logic         exp_cout, exp_ovf;
    full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_res  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = 1'b0;
`ifdef SUMA_OVF_EN
    exp_ovf  = (a[W-1] == b[W-1]) && (exp_res[W-1] != a[W-1]);
`endif
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; cin_i = cin;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      if (noisy) begin
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
      end else begin
        start_i = 1'b0;
      end
      check("busy_run", busy_o, 1);
      check("done_run", done_o, 0);
      check("add_a", add_a_o, a[k*WIDTH +: WIDTH]);
      check("add_b", add_b_o, b[k*WIDTH +: WIDTH]);
      check("add_cin", add_cin_o, carry_into(a, b, cin, k));
    end
    @(negedge clk);
    check("done_pulse", done_o, 1);
    check("busy_done", busy_o, 0);
    check("result", result_o, exp_res);
    check("cout", cout_o, exp_cout);
    check("ovf", ovf_o, exp_ovf);
    check("add_a_idle", add_a_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    check("done_once", done_o, 0);
    check("busy_idle", busy_o, 0);
    check("result_hold", result_o, exp_res);
    @(negedge clk);
    check("no_second_op", busy_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_cout", cout_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_add_cin", add_cin_o, 0);

    run_op(16'h7ADA, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
    run_op(16'h1234, 16'h0001, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

    // Reset during the first RUN cycle discards the operation.
    run_op(16'h1111, 16'h2222, 1'b1, 1'b0);
    @(negedge clk);
    start_i = 1'b1; a_i = 16'h4321; b_i = 16'h1111; cin_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_before_rst", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_result", result_o, 0);
    check("mid_rst_cout", cout_o, 0);
    for (int i = 0; i < WORDS + 1; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done_o, 0);
    end
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
